// File: rtl/veerwolf_uart_mon_pkg.sv
// Shared types and helpers for the VeeRwolf multi-channel UART receive monitor.
// Optional even-parity support is enabled with VEERWOLF_UART_MON_PARITY_EN.
package veerwolf_uart_mon_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } lane_state_t;

    localparam int CLK_DIV_DEFAULT = 868;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/veerwolf_uart_rx_lane.sv
// One 8N1 receive lane: synchroniser, frame FSM, shift register and byte FIFO.
// With VEERWOLF_UART_MON_PARITY_EN defined an even-parity bit follows the data bits.
module veerwolf_uart_rx_lane
    import veerwolf_uart_mon_pkg::*;
#(
    parameter int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx,
    input  logic              pop,
    output logic              empty,
    output logic              more,
    output logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] rdata_next,
    output logic              frame_err,
    output logic              overflow,
    output logic              parity_err
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] HALF     = CNT_W'(CLK_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    logic              rx_meta, rx_sync, rx_prev;
    lane_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              drop, stop_wait;
    logic              tick, push, wr_en, full;
    logic [AW:0]       wr_ptr, rd_ptr, count;
    logic [AW-1:0]     rd_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    assign tick = (cnt == '0);

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta   <= 1'b1;
            rx_sync   <= 1'b1;
            rx_prev   <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            drop      <= 1'b0;
            stop_wait <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
            case (state)
                IDLE: if (rx_prev && !rx_sync) begin
                    cnt       <= HALF;
                    drop      <= 1'b0;
                    stop_wait <= 1'b0;
                    state     <= START;
                end
                START: if (tick) begin
                    if (rx_sync) begin
                        state <= IDLE;
                    end else begin
                        cnt     <= FULL;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                DATA: if (tick) begin
                    shreg   <= {rx_sync, shreg[DATA_W-1:1]};
                    cnt     <= FULL;
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef VEERWOLF_UART_MON_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                PARITY: if (tick) begin
                    if (rx_sync != ^shreg) drop <= 1'b1;
                    cnt   <= FULL;
                    state <= STOP;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                STOP: if (stop_wait) begin
                    // Broken stop bit: hold here until the line returns high.
                    if (rx_sync) state <= IDLE;
                end else if (tick) begin
                    if (rx_sync) state <= IDLE;
                    else         stop_wait <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign frame_err = (state == STOP) && !stop_wait && tick && !rx_sync;
    assign push      = (state == STOP) && !stop_wait && tick &&  rx_sync && !drop;
`ifdef VEERWOLF_UART_MON_PARITY_EN
    assign parity_err = (state == PARITY) && tick && (rx_sync != ^shreg);
`else
    assign parity_err = 1'b0;
`endif

    // A simultaneous pop frees the slot the push lands in, so a full FIFO still accepts.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign more     = (count > (AW+1)'(1));
    assign wr_en    = push && (!full || pop);
    assign overflow = push && full && !pop;
    assign rd_next  = rd_ptr[AW-1:0] + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define its contents.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    assign rdata      = mem[rd_ptr[AW-1:0]];
    assign rdata_next = mem[rd_next];

endmodule

// File: rtl/veerwolf_uart_monitor.sv
// Multi-channel UART monitor: NUM_CH receive lanes merged into one round-robin byte stream.
// Parity checking is compiled in with VEERWOLF_UART_MON_PARITY_EN (otherwise o_parity_err stays 0).
module veerwolf_uart_monitor
    import veerwolf_uart_mon_pkg::*;
#(
    parameter  int NUM_CH     = 2,
    parameter  int CLK_DIV    = CLK_DIV_DEFAULT,
    parameter  int FIFO_DEPTH = 4,
    parameter  int DATA_W     = 8,
    localparam int CH_W       = ch_width(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] i_rx,
    input  logic              i_clr,
    output logic [DATA_W-1:0] o_data,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [NUM_CH-1:0] o_frame_err,
    output logic [NUM_CH-1:0] o_overflow,
    output logic [NUM_CH-1:0] o_parity_err
);

    logic [NUM_CH-1:0] lane_empty, lane_more, lane_pop, lane_ferr, lane_ovf, lane_perr;
    logic [DATA_W-1:0] lane_rdata [NUM_CH];
    logic [DATA_W-1:0] lane_rnext [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
        veerwolf_uart_rx_lane #(
            .CLK_DIV    (CLK_DIV),
            .FIFO_DEPTH (FIFO_DEPTH),
            .DATA_W     (DATA_W)
        ) u_lane (
            .clk        (clk),
            .rstn       (rstn),
            .rx         (i_rx[g]),
            .pop        (lane_pop[g]),
            .empty      (lane_empty[g]),
            .more       (lane_more[g]),
            .rdata      (lane_rdata[g]),
            .rdata_next (lane_rnext[g]),
            .frame_err  (lane_ferr[g]),
            .overflow   (lane_ovf[g]),
            .parity_err (lane_perr[g])
        );
    end

    // The displayed byte stays in its FIFO until handshaken, so it counts towards occupancy.
    logic              hs, take, gnt_found;
    logic [CH_W-1:0]   gnt_ch, rr_ptr;
    logic [NUM_CH-1:0] avail;
    logic [DATA_W-1:0] gnt_data;

    assign hs   = o_valid && i_ready;
    assign take = !o_valid || i_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        avail    = '0;
        lane_pop = '0;
        if (hs) lane_pop[o_ch] = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            avail[c] = (hs && int'(o_ch) == c) ? lane_more[c] : !lane_empty[c];
        end
        gnt_found = 1'b0;
        gnt_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (avail[(int'(rr_ptr) + i) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_ch    = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            end
        end
        gnt_data = (hs && gnt_ch == o_ch) ? lane_rnext[gnt_ch] : lane_rdata[gnt_ch];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_ch    <= '0;
            rr_ptr  <= '0;
        end else if (take) begin
            o_valid <= gnt_found;
            if (gnt_found) begin
                o_data <= gnt_data;
                o_ch   <= gnt_ch;
                rr_ptr <= (int'(gnt_ch) == NUM_CH - 1) ? '0 : gnt_ch + 1'b1;
            end
        end
    end

    // A new error in the same cycle as i_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            o_frame_err  <= '0;
            o_overflow   <= '0;
            o_parity_err <= '0;
        end else begin
            o_frame_err  <= (o_frame_err  & ~{NUM_CH{i_clr}}) | lane_ferr;
            o_overflow   <= (o_overflow   & ~{NUM_CH{i_clr}}) | lane_ovf;
            o_parity_err <= (o_parity_err & ~{NUM_CH{i_clr}}) | lane_perr;
        end
    end

endmodule

// File: tb/tb_veerwolf_uart_monitor.sv
// Directed bench for veerwolf_uart_monitor (CLK_DIV=16, NUM_CH=2, FIFO_DEPTH=4, DATA_W=8).
// Parity scenarios run when VEERWOLF_UART_MON_PARITY_EN is defined.
module tb_veerwolf_uart_monitor;

    localparam int NUM_CH = 2;
    localparam int CLK_DIV = 16;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  rx = 2'b11;
    logic        i_clr = 1'b0;
    logic        i_ready = 1'b1;
    logic [7:0]  o_data;
    logic [0:0]  o_ch;
    logic        o_valid;
    logic [1:0]  o_frame_err, o_overflow, o_parity_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    logic [8:0] beats[$];
    int         beat_t[$];

    veerwolf_uart_monitor #(
        .NUM_CH     (NUM_CH),
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (4),
        .DATA_W     (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_rx         (rx),
        .i_clr        (i_clr),
        .o_data       (o_data),
        .o_ch         (o_ch),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_frame_err  (o_frame_err),
        .o_overflow   (o_overflow),
        .o_parity_err (o_parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record each handshake (valid & ready seen mid-cycle completes on the next edge).
    always @(negedge clk) begin
        if (rstn && o_valid && i_ready) begin
            beats.push_back({o_ch, o_data});
            beat_t.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_beats();
        beats.delete();
        beat_t.delete();
    endtask

    task automatic send_frame(input int ch, input logic [7:0] data, input bit stop_bit, input bit bad_par);
        rx[ch] = 1'b0;
        step(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx[ch] = data[i];
            step(CLK_DIV);
        end
`ifdef VEERWOLF_UART_MON_PARITY_EN
        rx[ch] = (^data) ^ bad_par;
        step(CLK_DIV);
`endif
        rx[ch] = stop_bit;
        step(CLK_DIV);
        rx[ch] = 1'b1;
    endtask

    task automatic wait_beats(input int n, input string name);
        int budget = 200;
        while (beats.size() < n && budget > 0) begin
            step(1);
            budget--;
        end
        n_vec++;
        if (beats.size() != n) begin
            n_err++;
            $display("FAIL %s beat count: got %0d expected %0d", name, beats.size(), n);
        end
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step(2);
        rstn = 1'b1;
        step(2);
        clear_beats();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step(3);
        n_vec++;
        if ({o_valid, o_data, o_ch} !== 10'h0) begin
            n_err++;
            $display("FAIL reset outputs: got valid=%b data=%h ch=%h expected 0/00/0", o_valid, o_data, o_ch);
        end
        n_vec++;
        if ({o_frame_err, o_overflow, o_parity_err} !== 6'h0) begin
            n_err++;
            $display("FAIL reset flags: got %b expected 000000", {o_frame_err, o_overflow, o_parity_err});
        end
        rstn = 1'b1;
        step(5);
        n_vec++;
        if (o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle after reset valid: got %b expected 0", o_valid);
        end
    endtask

    task automatic test_single();
        clear_beats();
        send_frame(0, 8'hA5, 1'b1, 1'b0);
        wait_beats(1, "single");
        n_vec++;
        if (beats[0] !== 9'h0A5) begin
            n_err++;
            $display("FAIL single beat: got %h expected 0a5", beats[0]);
        end
        n_vec++;
        if ({o_frame_err, o_overflow, o_parity_err} !== 6'h0) begin
            n_err++;
            $display("FAIL single flags: got %b expected 000000", {o_frame_err, o_overflow, o_parity_err});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0 [2] = '{8'h3C, 8'h11};
        logic [7:0] d1 [2] = '{8'hC3, 8'h22};
        do_reset();
        for (int p = 0; p < 2; p++) begin
            clear_beats();
            fork
                send_frame(0, d0[p], 1'b1, 1'b0);
                send_frame(1, d1[p], 1'b1, 1'b0);
            join
            wait_beats(2, "pair");
            n_vec++;
            if (beats[0] !== {1'b0, d0[p]} || beats[1] !== {1'b1, d1[p]}) begin
                n_err++;
                $display("FAIL pair %0d order: got %h,%h expected %h,%h", p, beats[0], beats[1],
                         {1'b0, d0[p]}, {1'b1, d1[p]});
            end
            n_vec++;
            if (beat_t[1] - beat_t[0] !== 1) begin
                n_err++;
                $display("FAIL pair %0d spacing: got %0d cycles expected 1", p, beat_t[1] - beat_t[0]);
            end
        end
    endtask

    task automatic test_overflow();
        clear_beats();
        i_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(1, 8'(k), 1'b1, 1'b0);
            step(2);
            n_vec++;
            if ({o_valid, o_ch, o_data} !== 10'h301) begin
                n_err++;
                $display("FAIL stall hold after byte %0d: got valid=%b ch=%h data=%h expected 1/1/01",
                         k, o_valid, o_ch, o_data);
            end
            n_vec++;
            if (o_overflow !== ((k == 5) ? 2'b10 : 2'b00)) begin
                n_err++;
                $display("FAIL overflow after byte %0d: got %b expected %b", k, o_overflow,
                         (k == 5) ? 2'b10 : 2'b00);
            end
        end
        n_vec++;
        if (beats.size() != 0) begin
            n_err++;
            $display("FAIL stalled beats: got %0d expected 0", beats.size());
        end
        i_ready = 1'b1;
        wait_beats(4, "drain");
        step(10);
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (beats[k] !== 9'(9'h101 + k)) begin
                n_err++;
                $display("FAIL drain beat %0d: got %h expected %h", k, beats[k], 9'(9'h101 + k));
            end
        end
        n_vec++;
        if (beats.size() != 4 || beat_t[3] - beat_t[0] !== 3) begin
            n_err++;
            $display("FAIL drain total/span: got %0d beats span %0d expected 4 beats span 3",
                     beats.size(), beat_t[3] - beat_t[0]);
        end
    endtask

    task automatic test_frame_error();
        clear_beats();
        send_frame(0, 8'h55, 1'b0, 1'b0);
        step(20);
        n_vec++;
        if (o_frame_err !== 2'b01 || beats.size() != 0) begin
            n_err++;
            $display("FAIL frame error: got flags=%b beats=%0d expected 01 and 0", o_frame_err, beats.size());
        end
        send_frame(0, 8'h7E, 1'b1, 1'b0);
        wait_beats(1, "after frame error");
        n_vec++;
        if (beats[0] !== 9'h07E) begin
            n_err++;
            $display("FAIL recovery beat: got %h expected 07e", beats[0]);
        end
        i_clr = 1'b1;
        step(1);
        i_clr = 1'b0;
        n_vec++;
        if (o_frame_err !== 2'b00 || o_overflow !== 2'b00) begin
            n_err++;
            $display("FAIL clear: got frame=%b ovf=%b expected 00/00", o_frame_err, o_overflow);
        end
    endtask

    task automatic test_glitch_and_reset();
        clear_beats();
        rx[1] = 1'b0;
        step(4);
        rx[1] = 1'b1;
        step(40);
        n_vec++;
        if (beats.size() != 0 || {o_frame_err, o_overflow, o_parity_err} !== 6'h0) begin
            n_err++;
            $display("FAIL glitch: got beats=%0d flags=%b expected 0 and 000000",
                     beats.size(), {o_frame_err, o_overflow, o_parity_err});
        end
        // o_data still holds 0x7E here; the reset must clear it.
        fork
            send_frame(0, 8'hF8, 1'b1, 1'b0);
            begin
                step(90);
                rstn = 1'b0;
                step(1);
                n_vec++;
                if ({o_valid, o_data, o_ch} !== 10'h0) begin
                    n_err++;
                    $display("FAIL mid-frame reset: got valid=%b data=%h ch=%h expected 0/00/0",
                             o_valid, o_data, o_ch);
                end
                rstn = 1'b1;
            end
        join
        step(40);
        n_vec++;
        if (beats.size() != 0 || {o_frame_err, o_overflow, o_parity_err} !== 6'h0) begin
            n_err++;
            $display("FAIL partial frame: got beats=%0d flags=%b expected 0 and 000000",
                     beats.size(), {o_frame_err, o_overflow, o_parity_err});
        end
    endtask

    task automatic test_parity();
`ifdef VEERWOLF_UART_MON_PARITY_EN
        clear_beats();
        send_frame(0, 8'h0F, 1'b1, 1'b1);
        step(20);
        n_vec++;
        if (o_parity_err !== 2'b01 || beats.size() != 0) begin
            n_err++;
            $display("FAIL parity error: got flag=%b beats=%0d expected 01 and 0", o_parity_err, beats.size());
        end
        send_frame(0, 8'h0F, 1'b1, 1'b0);
        wait_beats(1, "good parity");
        n_vec++;
        if (beats[0] !== 9'h00F) begin
            n_err++;
            $display("FAIL good parity beat: got %h expected 00f", beats[0]);
        end
`else
        n_vec++;
        if (o_parity_err !== 2'b00) begin
            n_err++;
            $display("FAIL parity tie-off: got %b expected 00", o_parity_err);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_frame_error();
        test_glitch_and_reset();
        test_parity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
